// File: rtl/mx_pkg.sv
// Shared types and constants for the MXINT8 operand path: FP32 fields,
// E8M0 scale encoding, INT8 1.6 element format and the block FSM states.
package mx_pkg;

    localparam int BLOCK_SIZE_DEF = 32;
    localparam int ELEM_W_DEF     = 8;
    localparam int SCALE_W_DEF    = 8;
    localparam int FP_W_DEF       = 32;

    localparam logic [7:0] SCALE_NAN      = 8'hFF;
    localparam int         SCALE_BIAS     = 127;
    localparam logic [6:0] INT8_MAX       = 7'd127;
    localparam int         INT8_FRAC_BITS = 6;

    // Aligns the 23-bit FP32 fraction onto the 6 fractional bits of 1.6.
    localparam logic [8:0] SHIFT_BASE = 9'(23 - INT8_FRAC_BITS);
    localparam logic [8:0] SHIFT_MAX  = 9'd25;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        QUANT   = 2'd1,
        OUT     = 2'd2
    } state_t;

    function automatic logic [23:0] fp32_mant(input fp32_t f);
        return (f.exp == 8'd0) ? 24'd0 : {1'b1, f.frac};
    endfunction

endpackage

// File: rtl/mxint8_elem_quant.sv
// Combinational FP32 -> INT8 (1.6) element quantizer against a shared E8M0 scale.
// MXINT8_QUANT_RNE_EN selects round-to-nearest-even; otherwise magnitudes truncate.
module mxint8_elem_quant
    import mx_pkg::*;
(
    input  logic [31:0] fp32,
    input  logic [7:0]  scale,
    output logic [7:0]  elem,
    output logic        sat
);

    fp32_t       f;
    logic [8:0]  shift;
    logic [23:0] mant;
    logic [6:0]  mag;
    logic        over;

    assign f = fp32;

`ifdef MXINT8_QUANT_RNE_EN
    logic [49:0] ext;
    logic [23:0] q;
    logic        round_up;
    logic [8:0]  rounded;

    // Shift with 26 bits of headroom so guard and sticky survive the alignment.
    always_comb begin
        shift    = {1'b0, scale} - {1'b0, f.exp} + SHIFT_BASE;
        mant     = fp32_mant(f);
        ext      = {mant, 26'd0} >> shift;
        q        = ext[49:26];
        round_up = ext[25] & ((|ext[24:0]) | ext[26]);
        rounded  = {1'b0, q[7:0]} + {8'd0, round_up};
        over     = (|q[23:8]) | rounded[8] | rounded[7];
        mag      = over ? INT8_MAX : rounded[6:0];
    end
`else
    logic [23:0] q;

    // Truncation toward zero; the clamp can never fire for a |value| < 2.0.
    always_comb begin
        shift = {1'b0, scale} - {1'b0, f.exp} + SHIFT_BASE;
        mant  = fp32_mant(f);
        q     = mant >> shift;
        over  = |q[23:7];
        mag   = over ? INT8_MAX : q[6:0];
    end
`endif

    // Apply sign, and force zero for a NaN block or values below INT8 resolution.
    always_comb begin
        if ((scale == SCALE_NAN) || (shift > SHIFT_MAX)) begin
            elem = 8'd0;
            sat  = 1'b0;
        end else begin
            elem = f.sign ? (~{1'b0, mag} + 8'd1) : {1'b0, mag};
`ifdef MXINT8_QUANT_RNE_EN
            sat  = over;
`else
            sat  = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/mxint8_block_quantizer.sv
// Streaming FP32 -> MXINT8 block encoder: collect, quantize one element per cycle,
// present the block on valid/ready. Rounding mode set by MXINT8_QUANT_RNE_EN.
module mxint8_block_quantizer
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int ELEM_W     = ELEM_W_DEF,
    parameter int SCALE_W    = SCALE_W_DEF,
    parameter int FP_W       = FP_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [FP_W-1:0]              i_float32,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [SCALE_W-1:0]           o_scale,
    output logic [BLOCK_SIZE*ELEM_W-1:0] o_mxint8_elements,
    output logic                         o_nan,
    output logic                         o_sat
);

    localparam int              CNT_W = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_SIZE - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  qidx;
    logic [7:0]        max_exp;
    logic              nan_seen;
    logic              sat_acc;
    logic [FP_W-1:0]   word_buf [BLOCK_SIZE];

    logic [7:0]        in_exp;
    logic [7:0]        scale;
    logic [ELEM_W-1:0] q_elem;
    logic              q_sat;

    assign in_exp = i_float32[FP_W-2 -: 8];
    assign scale  = nan_seen ? SCALE_NAN : max_exp;

    mxint8_elem_quant u_quant (
        .fp32  (word_buf[qidx]),
        .scale (scale),
        .elem  (q_elem),
        .sat   (q_sat)
    );

    // Block FSM: collect words, quantize sequentially, hold the block until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= COLLECT;
            cnt               <= '0;
            qidx              <= '0;
            max_exp           <= 8'd0;
            nan_seen          <= 1'b0;
            sat_acc           <= 1'b0;
            o_ready           <= 1'b0;
            o_valid           <= 1'b0;
            o_scale           <= '0;
            o_mxint8_elements <= '0;
            o_nan             <= 1'b0;
            o_sat             <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                word_buf[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        word_buf[cnt] <= i_float32;
                        if (in_exp > max_exp) begin
                            max_exp <= in_exp;
                        end
                        if (in_exp == SCALE_NAN) begin
                            nan_seen <= 1'b1;
                        end
                        if (cnt == LAST) begin
                            cnt     <= '0;
                            qidx    <= '0;
                            o_ready <= 1'b0;
                            state   <= QUANT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                QUANT: begin
                    o_mxint8_elements[qidx*ELEM_W +: ELEM_W] <= q_elem;
                    sat_acc <= sat_acc | q_sat;
                    if (qidx == LAST) begin
                        o_valid <= 1'b1;
                        o_scale <= SCALE_W'(scale);
                        o_nan   <= nan_seen;
                        o_sat   <= sat_acc | q_sat;
                        state   <= OUT;
                    end else begin
                        qidx <= qidx + 1'b1;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid  <= 1'b0;
                        o_ready  <= 1'b1;
                        max_exp  <= 8'd0;
                        nan_seen <= 1'b0;
                        sat_acc  <= 1'b0;
                        cnt      <= '0;
                        qidx     <= '0;
                        state    <= COLLECT;
                    end
                end
                default: begin
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    state   <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/mxint8_block_quantizer.md
Name: mxint8_block_quantizer

Overview:
Streaming FP32 to MXINT8 encoder. It collects BLOCK_SIZE FP32 values, picks the shared E8M0 scale and quantizes each value to an INT8 element in 1.6 two's-complement format. It then presents one packed MXINT8 block on a valid/ready output. It is the producer side of the MXINT8 operand path and feeds the dot-product unit's i_scale_* and i_mxint8_elements_* operands.

Parameters:
BLOCK_SIZE, `BLOCK_SIZE (32), elements per MX block
ELEM_W, `MXINT8_ELEMENT_WIDTH (8), INT8 element width
SCALE_W, `SCALE_WIDTH (8), E8M0 scale width
FP_W, `FLOAT32_WIDTH (32), input FP32 width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
i_valid  in  1  input FP32 word valid
o_ready  out  1  block can accept an input word
i_float32  in  FP_W  FP32 input element
o_valid  out  1  output block valid
i_ready  in  1  downstream accepts the block
o_scale  out  SCALE_W  shared E8M0 scale
o_mxint8_elements  out  BLOCK_SIZE*ELEM_W  packed elements; element i is at [i*ELEM_W +: ELEM_W]
o_nan  out  1  block contains NaN/Inf
o_sat  out  1  at least one element was saturated

Behaviour:
- Reset: all outputs 0; o_ready=0 in the reset cycle, then 1; state=COLLECT; counters and buffer cleared. Reset mid-operation discards the partial or pending block.
- COLLECT: a word is accepted when i_valid&&o_ready, one per cycle.
  - The word is stored to buf[cnt] and cnt increments.
  - max_exp tracks the largest biased exponent among accepted words.
  - Exponent 0 (zero/subnormal) counts as 0.
  - Exponent 0xFF (NaN/Inf) sets nan_seen.
  - On the BLOCK_SIZE-th accept, go to QUANT with qidx=0. o_ready drops the following cycle.
- QUANT: one element per cycle, BLOCK_SIZE cycles, via mxint8_elem_quant.
  - scale = nan_seen ? 8'hFF : max_exp.
  - Magnitude m = {1,frac} (24 bits); zero/subnormal gives 0.
  - q = m >> (scale - exp + 17), rounded per the Optional Feature.
  - If shift > 25, q=0.
  - If q>127, clamp to 127 and set sat.
  - If negative, apply two's-complement negate. Range is symmetric, -127..127; 0x80 is never produced.
  - If nan_seen, all elements are 0.
- OUT: o_valid=1 and outputs are stable until i_valid... no: outputs are stable until i_ready.
  - On o_valid&&i_ready, o_valid drops next cycle, cnt/max_exp/nan_seen/sat clear, state returns to COLLECT and o_ready=1.
- Latency: if the last word is accepted at cycle T, o_valid rises at cycle T+BLOCK_SIZE+1.
- o_ready=0 throughout QUANT and OUT. No input is accepted or dropped there; the upstream must hold.
- Arithmetic: the shift amount is computed in 9-bit unsigned. Rounding carry into bit 7 is detected before the clamp.

Optional Feature:
Macro MXINT8_QUANT_RNE_EN.
- Defined: round-to-nearest-even using guard and sticky bits from the shifted-out bits. A round-up past 127 saturates and sets o_sat.
- Undefined: truncation toward zero on magnitude. o_sat is then only set when... it never is, because the magnitude is < 2.0 and truncation cannot exceed 127. o_sat is tied 0.

Decomposition:
- Shared package mx_pkg:
  - FP32 field typedef (sign/exp/frac).
  - E8M0 constants: SCALE_NAN=8'hFF, SCALE_BIAS=127.
  - INT8 constants: INT8_MAX=127, frac bits=6.
  - State enum {COLLECT, QUANT, OUT}.
- Sub-module mxint8_elem_quant: combinational (fp32, scale) -> (int8, sat).
  - The RNE/truncation macro is applied inside it.

Test Plan:
- 32x 0x3F800000 (1.0) -> o_scale=0x7F, every element 0x40, o_nan=0, o_sat=0; o_valid exactly 33 cycles after the last accept.
- Element 0 = 0x40400000 (3.0), rest 1.0 -> o_scale=0x80, element0=0x60, others=0x20.
- Element 3 = 0xBF800000 (-1.0), rest 1.0 -> element3=0xC0, o_scale=0x7F.
- Element 5 = 0x7FC00000 (NaN) -> o_scale=0xFF, all elements 0x00, o_nan=1.
- All 0x3FFFFFFF (~2.0):
  - With RNE_EN: elements 0x7F, o_sat=1.
  - Without: elements 0x7F, o_sat=0.
  - All-zero block -> o_scale=0x00, elements 0.
- Backpressure and reset: hold i_ready=0 for 5 cycles in OUT -> outputs stable, o_ready=0, i_valid words not consumed. Assert rst at cnt=10 -> o_valid=0; the next 32 words form a fresh block.
